// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

  localparam int CLKS_PER_BIT_DEFAULT = 217;
  localparam int DATA_BITS            = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs (serial line, buttons).
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: mid-bit sampling, start/stop validation, held output byte
// with one-cycle rx_valid / frame_err pulses.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] data_out,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [15:0] HALF = 16'((CLKS_PER_BIT - 1) / 2);
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

  rx_state_e   state_q;
  logic [15:0] clkCnt_q;
  logic [2:0]  bitIdx_q;
  logic [7:0]  shift_q;
  logic [7:0]  dataOut_q;
  logic        rxValid_q;
  logic        frameErr_q;
  logic        rxSync;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (rx_i),
    .q_o  (rxSync)
  );

  // Leaving STOP at mid-bit gives half a bit of slack for the next start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      clkCnt_q   <= '0;
      bitIdx_q   <= '0;
      shift_q    <= '0;
      dataOut_q  <= 8'h00;
      rxValid_q  <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      rxValid_q  <= 1'b0;
      frameErr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!rxSync) begin
            state_q  <= START;
            clkCnt_q <= '0;
          end
        end
        START: begin
          if (clkCnt_q == HALF) begin
            clkCnt_q <= '0;
            bitIdx_q <= '0;
            state_q  <= rxSync ? IDLE : DATA;
          end else begin
            clkCnt_q <= clkCnt_q + 16'd1;
          end
        end
        DATA: begin
          if (clkCnt_q == LAST) begin
            clkCnt_q          <= '0;
            shift_q[bitIdx_q] <= rxSync;
            if (bitIdx_q == LAST_BIT) begin
              state_q <= STOP;
            end else begin
              bitIdx_q <= bitIdx_q + 3'd1;
            end
          end else begin
            clkCnt_q <= clkCnt_q + 16'd1;
          end
        end
        STOP: begin
          if (clkCnt_q == LAST) begin
            clkCnt_q <= '0;
            if (rxSync) begin
              dataOut_q <= shift_q;
              rxValid_q <= 1'b1;
              state_q   <= IDLE;
            end else begin
              frameErr_q <= 1'b1;
              state_q    <= BREAK;
            end
          end else begin
            clkCnt_q <= clkCnt_q + 16'd1;
          end
        end
        BREAK: begin
          if (rxSync) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out  = dataOut_q;
  assign rx_valid  = rxValid_q;
  assign frame_err = frameErr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed testbench for uart_rx_byte at 16 clocks per bit.
module tb_uart_rx_byte;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_i = 1'b1;
  logic [7:0] data_out;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  int validCount = 0;
  int errCount = 0;
  int widthBad = 0;
  int overlapBad = 0;
  int changeBad = 0;
  int lastValidCyc = 0;
  logic [7:0] lastValidData = 8'h00;
  int validCycs[$];
  logic [7:0] validData[$];
  logic [7:0] prevData = 8'h00;
  logic prevValid = 1'b0;
  logic prevErr = 1'b0;

  uart_rx_byte #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_i     (rx_i),
    .data_out (data_out),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Passive record of pulses and output stability, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) begin
        validCount++;
        lastValidCyc = cyc;
        lastValidData = data_out;
        validCycs.push_back(cyc);
        validData.push_back(data_out);
      end
      if (frame_err) errCount++;
      if (rx_valid && prevValid) widthBad++;
      if (frame_err && prevErr) widthBad++;
      if (rx_valid && frame_err) overlapBad++;
      if ((data_out !== prevData) && !rx_valid) changeBad++;
    end
    prevData = data_out;
    prevValid = rx_valid;
    prevErr = frame_err;
  end

  // Caller must be aligned 1 time unit after a rising edge; returns aligned the same way.
  task automatic sendFrame(input logic [7:0] b, input logic stopBit, output int startCyc);
    startCyc = cyc;
    rx_i = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx_i = stopBit;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx_i = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", data_out); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", rx_valid); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b want=0", frame_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    rst_n = 1'b1;
    repeat (200) @(posedge clk);
    @(negedge clk);
    total++; if (validCount !== 0) begin bad++; $display("FAIL idle_valid got=%0d want=0", validCount); end
    total++; if (errCount !== 0) begin bad++; $display("FAIL idle_ferr got=%0d want=0", errCount); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", busy); end
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL idle_data got=%h want=00", data_out); end
  endtask

  task automatic test_single();
    int v0, e0, st, lat;
    v0 = validCount;
    e0 = errCount;
    @(posedge clk); #1;
    sendFrame(8'hA5, 1'b1, st);
    repeat (10) @(posedge clk);
    #1;
    lat = lastValidCyc - st;
    total++; if (validCount !== v0 + 1) begin bad++; $display("FAIL single_count got=%0d want=%0d", validCount, v0 + 1); end
    total++; if (lastValidData !== 8'hA5) begin bad++; $display("FAIL single_pulse_data got=%h want=a5", lastValidData); end
    total++; if (data_out !== 8'hA5) begin bad++; $display("FAIL single_data got=%h want=a5", data_out); end
    total++; if (lat < 154 || lat > 156) begin bad++; $display("FAIL single_latency got=%0d want=155+-1", lat); end
    total++; if (errCount !== e0) begin bad++; $display("FAIL single_ferr got=%0d want=%0d", errCount, e0); end
  endtask

  task automatic test_back_to_back();
    int n0, e0, st, gap;
    n0 = validCycs.size();
    e0 = errCount;
    sendFrame(8'h3C, 1'b1, st);
    sendFrame(8'hFF, 1'b1, st);
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (validCycs.size() !== n0 + 2) begin
      bad++; $display("FAIL b2b_count got=%0d want=%0d", validCycs.size(), n0 + 2);
    end else begin
      gap = validCycs[n0 + 1] - validCycs[n0];
      total++; if (gap < 159 || gap > 161) begin bad++; $display("FAIL b2b_gap got=%0d want=160+-1", gap); end
      total++; if (validData[n0] !== 8'h3C) begin bad++; $display("FAIL b2b_first got=%h want=3c", validData[n0]); end
      total++; if (validData[n0 + 1] !== 8'hFF) begin bad++; $display("FAIL b2b_second got=%h want=ff", validData[n0 + 1]); end
    end
    total++; if (data_out !== 8'hFF) begin bad++; $display("FAIL b2b_data got=%h want=ff", data_out); end
    total++; if (errCount !== e0) begin bad++; $display("FAIL b2b_ferr got=%0d want=%0d", errCount, e0); end
  endtask

  task automatic test_glitch();
    int v0, e0;
    v0 = validCount;
    e0 = errCount;
    rx_i = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_high got=%b want=1", busy); end
    rx_i = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_idle got=%b want=0", busy); end
    total++; if (validCount !== v0) begin bad++; $display("FAIL glitch_valid got=%0d want=%0d", validCount, v0); end
    total++; if (errCount !== e0) begin bad++; $display("FAIL glitch_ferr got=%0d want=%0d", errCount, e0); end
    total++; if (data_out !== 8'hFF) begin bad++; $display("FAIL glitch_data got=%h want=ff", data_out); end
  endtask

  task automatic test_frame_err();
    int v0, e0, st;
    v0 = validCount;
    e0 = errCount;
    sendFrame(8'h55, 1'b0, st);
    repeat (100) @(posedge clk);
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ferr_busy_break got=%b want=1", busy); end
    total++; if (errCount !== e0 + 1) begin bad++; $display("FAIL ferr_count got=%0d want=%0d", errCount, e0 + 1); end
    rx_i = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ferr_idle got=%b want=0", busy); end
    total++; if (validCount !== v0) begin bad++; $display("FAIL ferr_valid got=%0d want=%0d", validCount, v0); end
    total++; if (data_out !== 8'hFF) begin bad++; $display("FAIL ferr_data got=%h want=ff", data_out); end
    total++; if (errCount !== e0 + 1) begin bad++; $display("FAIL ferr_single got=%0d want=%0d", errCount, e0 + 1); end
  endtask

  task automatic test_reset_midframe();
    int v0, e0, st;
    logic [7:0] partial;
    partial = 8'h12;
    v0 = validCount;
    e0 = errCount;
    rx_i = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      rx_i = partial[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx_i = partial[4];
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL midrst_data got=%h want=00", data_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
    rx_i = 1'b1;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    total++; if (validCount !== v0) begin bad++; $display("FAIL midrst_valid got=%0d want=%0d", validCount, v0); end
    total++; if (errCount !== e0) begin bad++; $display("FAIL midrst_ferr got=%0d want=%0d", errCount, e0); end
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL midrst_hold got=%h want=00", data_out); end
    sendFrame(8'h34, 1'b1, st);
    repeat (5) @(posedge clk);
    #1;
    total++; if (validCount !== v0 + 1) begin bad++; $display("FAIL after_rst_count got=%0d want=%0d", validCount, v0 + 1); end
    total++; if (data_out !== 8'h34) begin bad++; $display("FAIL after_rst_data got=%h want=34", data_out); end
  endtask

  task automatic test_pulse_rules();
    total++; if (widthBad !== 0) begin bad++; $display("FAIL pulse_width got=%0d want=0", widthBad); end
    total++; if (overlapBad !== 0) begin bad++; $display("FAIL pulse_overlap got=%0d want=0", overlapBad); end
    total++; if (changeBad !== 0) begin bad++; $display("FAIL data_stable got=%0d want=0", changeBad); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_midframe();
    test_pulse_rules();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
